freq_regulator_param: RTL and testbench

- Parametrised next-generation frequency regulator for the function-generator datapath.
- Measures either the high time or the full rising-to-rising period of the feedback pulse `psi` in `clk` cycles, and compares it against a programmable target with a deadband.
- Steps the divider word `adjusted_div` up or down by a programmable amount, saturating at its limits.
- Adds overflow detection, a lock indicator and an enable; sits between the phase/pulse source and the clock divider.

---
 rtl/freq_reg_pkg.sv | 9 +
 rtl/freq_regulator_pulse_meter.sv | 90 +++++++++
 rtl/freq_regulator_param.sv | 110 +++++++++++
 tb/tb_freq_regulator_param.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/freq_reg_pkg.sv
// Shared types and constants for the frequency regulator.
package freq_reg_pkg;

  typedef enum logic {IDLE, MEASURE} meter_state_t;

  localparam logic MODE_HIGH   = 1'b0;
  localparam logic MODE_PERIOD = 1'b1;

endpackage

// File: rtl/freq_regulator_pulse_meter.sv
// Measures the high time or rise-to-rise period of psi in clk cycles,
// with a saturating counter and sticky overflow.
module pulse_meter
  import freq_reg_pkg::*;
#(
  parameter int CNT_W = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             psi,
  input  logic             mode,
  output logic [CNT_W-1:0] meas,
  output logic             done,
  output logic             ovf,
  output logic             abort
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  meter_state_t     state, state_next;
  logic [CNT_W-1:0] count, count_next;
  logic             ovf_q, ovf_next;
  logic             meas_mode, meas_mode_next;
  logic             prev_psi;
  logic             rise, fall, end_edge;

  assign rise     = psi & ~prev_psi;
  assign fall     = ~psi & prev_psi;
  assign end_edge = (mode == MODE_PERIOD) ? rise : fall;

  // A mode change mid-measurement would mix two kinds of result, so it aborts.
  assign abort = (state == MEASURE) && (!en || (mode != meas_mode));
  assign done  = (state == MEASURE) && !abort && end_edge;
  assign meas  = count;
  assign ovf   = ovf_q;

  always_comb begin
    state_next     = state;
    count_next     = count;
    ovf_next       = ovf_q;
    meas_mode_next = meas_mode;
    case (state)
      IDLE: begin
        if (rise && en) begin
          state_next     = MEASURE;
          count_next     = {{(CNT_W-1){1'b0}}, 1'b1};
          ovf_next       = 1'b0;
          meas_mode_next = mode;
        end
      end
      MEASURE: begin
        if (abort) begin
          state_next = IDLE;
          count_next = '0;
          ovf_next   = 1'b0;
        end else if (end_edge) begin
          ovf_next = 1'b0;
          if (mode == MODE_PERIOD) begin
            count_next = {{(CNT_W-1){1'b0}}, 1'b1};
          end else begin
            state_next = IDLE;
            count_next = '0;
          end
        end else if (count == CNT_MAX) begin
          ovf_next = 1'b1;
        end else begin
          count_next = count + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      ovf_q     <= 1'b0;
      meas_mode <= MODE_HIGH;
      prev_psi  <= 1'b0;
    end else begin
      state     <= state_next;
      count     <= count_next;
      ovf_q     <= ovf_next;
      meas_mode <= meas_mode_next;
      prev_psi  <= psi;
    end
  end

endmodule

// File: rtl/freq_regulator_param.sv
// Frequency regulator: compares each psi measurement against a target with
// deadband, steps the divider word with saturation and tracks lock.
module freq_regulator_param
  import freq_reg_pkg::*;
#(
  parameter int DIV_W    = 8,
  parameter int CNT_W    = 9,
  parameter int STEP_W   = 4,
  parameter int DIV_INIT = 2**(DIV_W-1)-1,
  parameter int DIV_MIN  = 1,
  parameter int LOCK_N   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              psi,
  input  logic              mode,
  input  logic [CNT_W-1:0]  set_period,
  input  logic [CNT_W-1:0]  deadband,
  input  logic [STEP_W-1:0] step,
  output logic [DIV_W-1:0]  adjusted_div,
  output logic [CNT_W-1:0]  duration,
  output logic              meas_valid,
  output logic              inc,
  output logic              dec,
  output logic              overflow,
  output logic              locked
);

  localparam int LOCK_W = $clog2(LOCK_N + 1);
  localparam logic [DIV_W:0]    DIV_MAX_W = {1'b0, {DIV_W{1'b1}}};
  localparam logic [DIV_W:0]    DIV_MIN_W = (DIV_W+1)'(DIV_MIN);
  localparam logic [LOCK_W-1:0] LOCK_FULL = LOCK_W'(LOCK_N);

  logic [CNT_W-1:0]  meas;
  logic              done, ovf, abort;
  logic [CNT_W:0]    meas_w, hi_bound, lo_sum;
  logic              too_long, too_short;
  logic [DIV_W:0]    div_w, step_w, up_sum, dn_diff, floor_sum;
  logic [DIV_W-1:0]  div_up, div_dn;
  logic [LOCK_W-1:0] lock_cnt;

  pulse_meter #(.CNT_W(CNT_W)) u_meter (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .psi   (psi),
    .mode  (mode),
    .meas  (meas),
    .done  (done),
    .ovf   (ovf),
    .abort (abort)
  );

  // One extra bit on every sum so the bounds never wrap.
  always_comb begin
    meas_w    = {1'b0, meas};
    hi_bound  = {1'b0, set_period} + {1'b0, deadband};
    lo_sum    = meas_w + {1'b0, deadband};
    too_long  = ovf | (meas_w > hi_bound);
    too_short = ~ovf & (lo_sum < {1'b0, set_period});
  end

  always_comb begin
    div_w     = {1'b0, adjusted_div};
    step_w    = (DIV_W+1)'(step);
    up_sum    = div_w + step_w;
    dn_diff   = div_w - step_w;
    floor_sum = step_w + DIV_MIN_W;
    div_up    = (up_sum > DIV_MAX_W) ? DIV_MAX_W[DIV_W-1:0] : up_sum[DIV_W-1:0];
    div_dn    = (div_w < floor_sum) ? DIV_MIN_W[DIV_W-1:0] : dn_diff[DIV_W-1:0];
  end

  assign locked = (lock_cnt == LOCK_FULL);

  always_ff @(posedge clk) begin
    if (rst) begin
      adjusted_div <= DIV_W'(DIV_INIT);
      duration     <= '0;
      meas_valid   <= 1'b0;
      inc          <= 1'b0;
      dec          <= 1'b0;
      overflow     <= 1'b0;
      lock_cnt     <= '0;
    end else begin
      meas_valid <= done;
      inc        <= done & too_long;
      dec        <= done & too_short;
      overflow   <= done & ovf;
      if (done) begin
        duration <= meas;
        if (too_long) begin
          adjusted_div <= div_up;
        end else if (too_short) begin
          adjusted_div <= div_dn;
        end
      end
      if (abort || !en) begin
        lock_cnt <= '0;
      end else if (done) begin
        if (too_long || too_short) begin
          lock_cnt <= '0;
        end else if (lock_cnt != LOCK_FULL) begin
          lock_cnt <= lock_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_freq_regulator_param.sv
// Scoreboard bench for freq_regulator_param: directed pulses push expected
// results; a negedge monitor pops and compares on every meas_valid.
module tb_freq_regulator_param;
  import freq_reg_pkg::*;

  logic       clk = 1'b0;
  logic       rst, en, psi, mode;
  logic [8:0] set_period, deadband;
  logic [3:0] step;
  logic [7:0] adjusted_div;
  logic [8:0] duration;
  logic       meas_valid, inc, dec, overflow, locked;

  typedef struct {
    int dur;
    bit inc_e;
    bit dec_e;
    bit ovf_e;
    int div;
    bit lock_e;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  freq_regulator_param dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .psi          (psi),
    .mode         (mode),
    .set_period   (set_period),
    .deadband     (deadband),
    .step         (step),
    .adjusted_div (adjusted_div),
    .duration     (duration),
    .meas_valid   (meas_valid),
    .inc          (inc),
    .dec          (dec),
    .overflow     (overflow),
    .locked       (locked)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Monitor: every completed measurement must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (meas_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_meas: got duration %0d expected no measurement", duration);
      end else begin
        e = exp_q.pop_front();
        check_output("duration", int'(duration), e.dur);
        check_output("inc", int'(inc), int'(e.inc_e));
        check_output("dec", int'(dec), int'(e.dec_e));
        check_output("overflow", int'(overflow), int'(e.ovf_e));
        check_output("adjusted_div", int'(adjusted_div), e.div);
        check_output("locked", int'(locked), int'(e.lock_e));
      end
    end else if (inc || dec || overflow) begin
      checks++;
      errors++;
      $display("[TB] FAIL stray_flag: got inc %0d dec %0d ovf %0d expected all 0", inc, dec, overflow);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input int high, input int low);
    psi = 1'b1;
    tick(high);
    psi = 1'b0;
    tick(low);
  endtask

  task automatic expect_meas(input int dur, input bit i, input bit d, input bit o,
                             input int div, input bit lk);
    exp_t e;
    e.dur = dur; e.inc_e = i; e.dec_e = d; e.ovf_e = o; e.div = div; e.lock_e = lk;
    exp_q.push_back(e);
  endtask

  task automatic pulse(input int high, input int dur, input bit i, input bit d,
                       input bit o, input int div, input bit lk);
    expect_meas(dur, i, d, o, div, lk);
    apply_stimulus(high, 4);
  endtask

  task automatic check_reset_state();
    @(negedge clk);
    check_output("rst_div", int'(adjusted_div), 127);
    check_output("rst_duration", int'(duration), 0);
    check_output("rst_meas_valid", int'(meas_valid), 0);
    check_output("rst_inc", int'(inc), 0);
    check_output("rst_dec", int'(dec), 0);
    check_output("rst_overflow", int'(overflow), 0);
    check_output("rst_locked", int'(locked), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; psi = 1'b0; mode = MODE_HIGH;
    set_period = 9'd10; deadband = 9'd0; step = 4'd1;
    tick(3);
    rst = 1'b0;
    check_reset_state();

    // Give duration a nonzero value, then reset in the middle of a pulse.
    pulse(12, 12, 1, 0, 0, 128, 0);
    psi = 1'b1;
    tick(5);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    psi = 1'b0;
    check_reset_state();
    tick(4);

    pulse(12, 12, 1, 0, 0, 128, 0);
    pulse(8, 8, 0, 1, 0, 127, 0);

    deadband = 9'd2;
    for (int i = 0; i < 5; i++) pulse(11, 11, 0, 0, 0, 127, i >= 3);
    pulse(13, 13, 1, 0, 0, 128, 0);

    // Climb to 250, then saturate at 255, then overflow the counter.
    step = 4'd8;
    for (int i = 0; i < 15; i++) pulse(15, 15, 1, 0, 0, 128 + 8 * (i + 1), 0);
    step = 4'd2;
    pulse(15, 15, 1, 0, 0, 250, 0);
    step = 4'd8;
    pulse(15, 15, 1, 0, 0, 255, 0);
    pulse(15, 15, 1, 0, 0, 255, 0);
    pulse(600, 511, 1, 0, 1, 255, 0);

    // Descend to 5, then clamp at DIV_MIN.
    step = 4'd15;
    for (int i = 0; i < 16; i++) pulse(3, 3, 0, 1, 0, 255 - 15 * (i + 1), 0);
    step = 4'd10;
    pulse(3, 3, 0, 1, 0, 5, 0);
    step = 4'd8;
    pulse(3, 3, 0, 1, 0, 1, 0);
    pulse(3, 3, 0, 1, 0, 1, 0);
    step = 4'd0;
    pulse(3, 3, 0, 1, 0, 1, 0);

    // Period mode: first rise only arms.
    tick(2);
    mode = MODE_PERIOD; set_period = 9'd20; deadband = 9'd0; step = 4'd1;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) expect_meas(20, 0, 0, 0, 1, k >= 4);
      apply_stimulus(5, 15);
    end
    en = 1'b0;
    tick(1);
    @(negedge clk);
    check_output("abort_locked", int'(locked), 0);
    check_output("abort_div", int'(adjusted_div), 1);
    check_output("abort_duration", int'(duration), 20);
    tick(2);
    en = 1'b1;
    apply_stimulus(5, 15);
    mode = MODE_HIGH;
    tick(30);

    check_output("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
